// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback controller.
//   DSIZE : data width of a register
//   NREG  : number of architectural registers
//   RSIZE : register address width
//   wb_entry_t : one queued load writeback {live, addr, data}
package rf_pkg;

    localparam int unsigned DSIZE = 16;
    localparam int unsigned NREG  = 16;
    localparam int unsigned RSIZE = 4;

    typedef struct packed {
        logic             live;
        logic [RSIZE-1:0] addr;
        logic [DSIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_kill_fifo.sv
// Circular queue of pending load writebacks whose entries can be killed in place.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i          : write push_entry_i at the tail
//   pop_i           : retire the head entry
//   kill_en_i       : clear the live bit of every entry whose addr equals kill_addr_i
//   head_o          : current head entry (meaningful only when count_o != 0)
//   count_o         : occupied entries, live and dead
//   entries_o       : full storage array, used for the pending decode
module wb_kill_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  wb_entry_t                      push_entry_i,
    input  logic                           pop_i,
    input  logic                           kill_en_i,
    input  logic [RSIZE-1:0]               kill_addr_i,
    output wb_entry_t                      head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output wb_entry_t [DEPTH-1:0]          entries_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (kill_en_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (mem_q[i].addr == kill_addr_i) begin
                    mem_d[i].live = 1'b0;
                end
            end
        end

        // Retired slots are cleared so the pending decode can scan the whole array.
        if (pop_i) begin
            mem_d[head_q].live = 1'b0;
            head_d             = head_q + PW'(1);
        end

        // Push never targets the popped slot: pushes only happen when not full.
        if (push_i) begin
            mem_d[tail_q] = push_entry_i;
            tail_d        = tail_q + PW'(1);
        end

        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o    = mem_q[head_q];
    assign count_o   = count_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Write-port driver for the register file. ALU results issue the next edge with strict
// priority; load results queue in order and issue in cycles the ALU leaves free. A newer
// ALU write kills queued loads to the same register.
//   clk, rst                         : clock, asynchronous active-low reset
//   alu_valid/alu_waddr/alu_wdata    : ALU writeback request (no backpressure)
//   ld_valid/ld_waddr/ld_wdata       : load writeback request, accepted when ld_ready
//   rf_wen/rf_waddr/rf_wdata         : registered register-file write port
//   pending                          : per-register live queued write mask
//   fifo_count                       : occupied queue entries, live and dead
//   overflow_err                     : sticky, load presented while not ready
module rf_writeback_ctrl
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_valid,
    input  logic [RSIZE-1:0]               alu_waddr,
    input  logic [DSIZE-1:0]               alu_wdata,
    input  logic                           ld_valid,
    input  logic [RSIZE-1:0]               ld_waddr,
    input  logic [DSIZE-1:0]               ld_wdata,
    output logic                           ld_ready,
    output logic                           rf_wen,
    output logic [RSIZE-1:0]               rf_waddr,
    output logic [DSIZE-1:0]               rf_wdata,
    output logic [NREG-1:0]                pending,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count,
    output logic                           overflow_err
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    wb_entry_t             head;
    wb_entry_t             push_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [CW-1:0]         count;

    logic alu_issue, ld_push, head_valid, ld_issue, ld_pop;

    logic             wen_q, wen_d;
    logic [RSIZE-1:0] waddr_q, waddr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic             ovf_q, ovf_d;

    assign alu_issue  = alu_valid && (alu_waddr != '0);
    assign ld_ready   = (count < DepthCnt);
    assign ld_push    = ld_valid && ld_ready && (ld_waddr != '0);
    assign head_valid = (count != '0);
    assign ld_issue   = head_valid && head.live && !alu_issue;
    // Dead heads retire every cycle, even under an ALU write, so they never block the queue.
    assign ld_pop     = head_valid && (!head.live || !alu_issue);

    // A same-cycle load is older than the ALU result, so it is born dead on a match.
    assign push_entry = '{live: !(alu_issue && (ld_waddr == alu_waddr)),
                          addr: ld_waddr,
                          data: ld_wdata};

    wb_kill_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .push_i       (ld_push),
        .push_entry_i (push_entry),
        .pop_i        (ld_pop),
        .kill_en_i    (alu_issue),
        .kill_addr_i  (alu_waddr),
        .head_o       (head),
        .count_o      (count),
        .entries_o    (entries)
    );

    // Retired slots are dead, so scanning every slot gives exactly the live queued writes.
    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].live) begin
                pending[entries[i].addr] = 1'b1;
            end
        end
    end

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_issue) begin
            wen_d   = 1'b1;
            waddr_d = alu_waddr;
            wdata_d = alu_wdata;
        end else if (ld_issue) begin
            wen_d   = 1'b1;
            waddr_d = head.addr;
            wdata_d = head.data;
        end
        ovf_d = ovf_q || (ld_valid && !ld_ready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rf_wen       = wen_q;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign fifo_count   = count;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomized and directed bench for rf_writeback_ctrl against a queue-based reference model.
module tb_rf_writeback_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_waddr = '0;
    logic [15:0] alu_wdata = '0;
    logic        ld_valid = 1'b0;
    logic [3:0]  ld_waddr = '0;
    logic [15:0] ld_wdata = '0;
    logic        ld_ready;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] pending;
    logic [2:0]  fifo_count;
    logic        overflow_err;

    rf_writeback_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_waddr    (alu_waddr),
        .alu_wdata    (alu_wdata),
        .ld_valid     (ld_valid),
        .ld_waddr     (ld_waddr),
        .ld_wdata     (ld_wdata),
        .ld_ready     (ld_ready),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pending      (pending),
        .fifo_count   (fifo_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order list of queued loads plus the expected output registers.
    typedef struct {
        bit live;
        int addr;
        int data;
    } m_ent_t;

    m_ent_t mq[$];
    bit     exp_wen;
    int     exp_waddr;
    int     exp_wdata;
    bit     exp_ovf;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
        return m;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".wen"},     32'(rf_wen),       32'(exp_wen));
        check({tag, ".waddr"},   32'(rf_waddr),     32'(exp_waddr));
        check({tag, ".wdata"},   32'(rf_wdata),     32'(exp_wdata));
        check({tag, ".pending"}, 32'(pending),      model_pending());
        check({tag, ".count"},   32'(fifo_count),   32'(mq.size()));
        check({tag, ".ready"},   32'(ld_ready),     32'(mq.size() < DEPTH));
        check({tag, ".ovf"},     32'(overflow_err), 32'(exp_ovf));
    endtask

    // Apply one cycle of inputs, advance the model by the behavioural rules, then compare.
    task automatic step(input string tag, input bit av, input int aa, input int ad,
                        input bit lv, input int la, input int ld);
        bit aiss;
        bit rdy;
        alu_valid = av;
        alu_waddr = 4'(aa);
        alu_wdata = 16'(ad);
        ld_valid  = lv;
        ld_waddr  = 4'(la);
        ld_wdata  = 16'(ld);

        aiss    = av && (aa != 0);
        rdy     = mq.size() < DEPTH;
        exp_wen = 1'b0;
        if (aiss) begin
            exp_wen   = 1'b1;
            exp_waddr = aa;
            exp_wdata = ad;
        end
        if (mq.size() > 0) begin
            if (!mq[0].live) begin
                mq.delete(0);
            end else if (!aiss) begin
                exp_wen   = 1'b1;
                exp_waddr = mq[0].addr;
                exp_wdata = mq[0].data;
                mq.delete(0);
            end
        end
        if (aiss) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
        if (lv && !rdy) exp_ovf = 1'b1;
        if (lv && rdy && (la != 0)) mq.push_back('{live: !(aiss && la == aa), addr: la, data: ld});

        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        mq.delete();
        exp_wen   = 1'b0;
        exp_waddr = 0;
        exp_wdata = 0;
        exp_ovf   = 1'b0;
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        exp_wen = 0; exp_waddr = 0; exp_wdata = 0; exp_ovf = 0;
        @(posedge clk);
        do_reset();
        check_all("reset");
        idle("idle", 3);

        // ALU r3 = 0x1234
        step("alu_r3", 1, 3, 'h1234, 0, 0, 0);
        check("alu_r3.addr_const", 32'(rf_waddr), 32'd3);
        check("alu_r3.data_const", 32'(rf_wdata), 32'h1234);
        idle("alu_r3_after", 1);
        check("alu_r3.wen_drop", 32'(rf_wen), 32'd0);

        // Load r5 = 0xBEEF
        step("ld_r5_e1", 0, 0, 0, 1, 5, 'hBEEF);
        check("ld_r5.pending5", 32'(pending[5]), 32'd1);
        idle("ld_r5_e2", 1);
        check("ld_r5.data_const", 32'(rf_wdata), 32'hBEEF);
        idle("ld_r5_tail", 1);

        // ALU r1..r6 while loads r8..r12 arrive: queue fills, r12 overflows
        for (int i = 0; i < 6; i++)
            step("burst", 1, 1 + i, 'h100 + i, i < 5, 8 + i, 'h800 + i);
        check("burst.ovf_const", 32'(overflow_err), 32'd1);
        idle("drain", 6);
        check("drain.ovf_sticky", 32'(overflow_err), 32'd1);

        // WAW kill on r7
        step("waw_ld", 0, 0, 0, 1, 7, 'h0001);
        step("waw_alu", 1, 7, 'h0002, 0, 0, 0);
        check("waw.pending7", 32'(pending[7]), 32'd0);
        idle("waw_pop", 2);

        // Register 0 from both sources, plus a same-cycle kill
        step("r0", 1, 0, 'h5555, 1, 0, 'h6666);
        step("same_cyc", 1, 9, 'h9999, 1, 9, 'h4444);
        idle("r0_after", 2);

        // Reset with three loads queued behind a busy ALU
        for (int i = 0; i < 3; i++) step("prerst", 1, 1, 'h10 + i, 1, 8 + i, 'h20 + i);
        #2;
        do_reset();
        idle("post_rst", 4);

        // Random traffic with a mid-run reset
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 16'hFFFF)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)));
        end
        idle("final", 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
